shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier_pkg.sv | 24 ++
 rtl/shift_add_multiplier.sv | 159 +++++++++++++++
 tb/tb_shift_add_multiplier.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   - default operand width
//   - FSM state encoding (fixed values so benches can probe r_state)
// ---------------------------------------------------------------------------
package shift_add_multiplier_pkg;

   // Operand width used when the parent does not override BIT_LENGTH.
   localparam int BIT_LENGTH_DEFAULT = 16;

   // Fixed encodings: IDLE=0, CALC=1, DONE=2.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Width of the iteration counter for a given operand width.
   function automatic int cnt_width(input int bit_length);
      return $clog2(bit_length + 1);
   endfunction

endpackage : shift_add_multiplier_pkg

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
// Sequential unsigned multiplier, one partial product per clock. Feeds the
// adder of the multiply-accumulate path: Product -> addend, Done -> Add.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting; Start latches A/B, clears accumulator and counter
// CALC  | BIT_LENGTH add/shift iterations, then one cycle to publish
// DONE  | Product holds the new result, Done pulses for this cycle only
//
// Ports:
//   Clk      in   rising-edge clock
//   Rst      in   synchronous, active-high reset
//   Start    in   multiply request, sampled only while Busy=0
//   A, B     in   unsigned operands, latched on accepted Start
//   Busy     out  high from the accepting edge through the Done cycle
//   Done     out  one-cycle completion pulse
//   Product  out  registered 2*BIT_LENGTH result, changes only entering DONE
// ---------------------------------------------------------------------------
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int BIT_LENGTH = BIT_LENGTH_DEFAULT
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    Start,
   input  logic [BIT_LENGTH-1:0]   A,
   input  logic [BIT_LENGTH-1:0]   B,
   output logic                    Busy,
   output logic                    Done,
   output logic [2*BIT_LENGTH-1:0] Product
);

   localparam int              PW       = 2 * BIT_LENGTH;
   localparam int              CW       = cnt_width(BIT_LENGTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(BIT_LENGTH);

   state_t                r_state;
   state_t                w_state_next;

   logic [PW-1:0]         r_mcand;
   logic [BIT_LENGTH-1:0] r_mplier;
   logic [PW-1:0]         r_acc;
   logic [CW-1:0]         r_count;
   logic [PW-1:0]         r_product;

   logic                  w_accept;
   logic                  w_iter;
   logic                  w_publish;
   logic                  w_busy;
   logic                  w_done;

   // Start is only honoured in IDLE, so anything arriving while busy
   // (including the DONE cycle) is simply dropped.
   assign w_accept  = (r_state == ST_IDLE) && Start;
   assign w_iter    = (r_state == ST_CALC) && (r_count != CNT_LAST);
   assign w_publish = (r_state == ST_CALC) && (r_count == CNT_LAST);

   // ---------------- state register ----------------
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (Start) begin
               w_state_next = ST_CALC;
            end
         end
         ST_CALC: begin
            // The cycle after the last iteration publishes the result.
            if (r_count == CNT_LAST) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------- output decode ----------------
   // Decoded purely from the state register: no input-to-output path.
   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            w_done = 1'b0;
         end
         ST_CALC: begin
            w_busy = 1'b1;
            w_done = 1'b0;
         end
         ST_DONE: begin
            w_busy = 1'b1;
            w_done = 1'b1;
         end
         default: begin
            w_busy = 1'b0;
            w_done = 1'b0;
         end
      endcase
   end

   assign Busy    = w_busy;
   assign Done    = w_done;
   assign Product = r_product;

   // ---------------- datapath ----------------
   // Multiplicand is held at full product width so it can be shifted left
   // BIT_LENGTH-1 times without losing bits; the largest result
   // (2^BIT_LENGTH-1)^2 fits in the accumulator.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_count   <= '0;
         r_product <= '0;
      end else begin
         if (w_accept) begin
            r_mcand  <= {{BIT_LENGTH{1'b0}}, A};
            r_mplier <= B;
            r_acc    <= '0;
            r_count  <= '0;
         end

         if (w_iter) begin
            if (r_mplier[0]) begin
               r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CW'(1);
         end

         // Product is only written here, so downstream never sees a
         // partially accumulated value.
         if (w_publish) begin
            r_product <= r_acc;
         end
      end
   end

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier at BIT_LENGTH=16.
// A timing-level model (accept edge k -> Done after edge k+N+1, idle after
// k+N+2, product = A*B) is compared against Busy/Done/Product every cycle;
// directed scenarios add literal checks on products, latency and an
// accumulated "adder" sum.
module tb_shift_add_multiplier;

   localparam int N  = 16;
   localparam int PW = 2 * N;

   logic          Clk   = 1'b0;
   logic          Rst   = 1'b1;
   logic          Start = 1'b0;
   logic [N-1:0]  A     = '0;
   logic [N-1:0]  B     = '0;
   logic          Busy;
   logic          Done;
   logic [PW-1:0] Product;

   int errors = 0;
   int checks = 0;

   shift_add_multiplier #(.BIT_LENGTH(N)) dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .Start   (Start),
      .A       (A),
      .B       (B),
      .Busy    (Busy),
      .Done    (Done),
      .Product (Product)
   );

   always #5 Clk = ~Clk;

   // ---------------- behavioural model ----------------
   int            cyc      = 0;
   bit            m_active = 1'b0;
   bit            m_was    = 1'b0;
   bit            m_done   = 1'b0;
   bit            m_busy   = 1'b0;
   int            m_start  = 0;
   logic [PW-1:0] m_pend    = '0;
   logic [PW-1:0] m_product = '0;

   always @(posedge Clk) begin
      cyc++;
      if (Rst) begin
         m_active  = 1'b0;
         m_done    = 1'b0;
         m_product = '0;
      end else begin
         m_was  = m_active;
         m_done = 1'b0;
         if (m_active && cyc == m_start + N + 1) begin
            m_done    = 1'b1;
            m_product = m_pend;
         end
         if (m_active && cyc == m_start + N + 2) m_active = 1'b0;
         if (!m_was && Start) begin
            m_active = 1'b1;
            m_start  = cyc;
            m_pend   = PW'(A) * PW'(B);
         end
      end
      m_busy = m_active;
   end

   // Downstream adder stand-in: sum accumulates Product on each Done.
   logic [PW+7:0] sum = '0;
   always @(posedge Clk) begin
      if (Rst)       sum <= '0;
      else if (Done) sum <= sum + (PW+8)'(Product);
   end

   // ---------------- per-cycle compare ----------------
   bit check_en = 1'b0;
   always @(negedge Clk) begin
      if (check_en) begin
         checks++;
         if (Busy !== m_busy) begin
            errors++;
            $display("FAIL busy @cyc %0d: got %b want %b", cyc, Busy, m_busy);
         end
         checks++;
         if (Done !== m_done) begin
            errors++;
            $display("FAIL done @cyc %0d: got %b want %b", cyc, Done, m_done);
         end
         checks++;
         if (Product !== m_product) begin
            errors++;
            $display("FAIL product @cyc %0d: got %h want %h", cyc, Product, m_product);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Present A/B with Start for one edge, then scramble A/B so the bench
   // would notice if the DUT used live operands.
   task automatic do_start(input logic [N-1:0] a, input logic [N-1:0] b);
      @(posedge Clk); #1;
      Start = 1'b1; A = a; B = b;
      @(posedge Clk); #1;
      Start = 1'b0; A = N'($urandom); B = N'($urandom);
   endtask

   // Called #1 after the accepting edge; returns cycles until Done.
   task automatic wait_done(input string name, output int lat);
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (Done === 1'b1) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) begin
         errors++;
         checks++;
         $display("FAIL %s timeout: got no Done want Done within 40 cycles", name);
      end
   endtask

   task automatic run_mul(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [PW-1:0] exp);
      int lat;
      do_start(a, b);
      wait_done(name, lat);
      check({name, " latency"}, 64'(lat), 64'(N + 1));
      check({name, " product"}, 64'(Product), 64'(exp));
   endtask

   task automatic count_done(input int ncyc, output int n);
      n = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge Clk);
         if (Done === 1'b1) n++;
      end
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int n;
      int lat;

      Rst = 1'b1;
      @(posedge Clk); #1;
      check_en = 1'b1;
      check("reset product", 64'(Product), 64'd0);
      check("reset done",    64'(Done),    64'd0);
      check("reset busy",    64'(Busy),    64'd0);
      Rst = 1'b0;

      run_mul("3x5",       16'd3,      16'd5,      32'd15);
      run_mul("ffffxffff", 16'hFFFF,   16'hFFFF,   32'hFFFE0001);
      run_mul("0x1234",    16'd0,      16'h1234,   32'd0);

      // Second Start two cycles later must be dropped.
      @(posedge Clk); #1;
      Start = 1'b1; A = 16'd7; B = 16'd9;
      @(posedge Clk); #1;
      Start = 1'b0;
      @(posedge Clk); #1;
      Start = 1'b1; A = 16'd2; B = 16'd2;
      @(posedge Clk); #1;
      Start = 1'b0;
      count_done(30, n);
      check("ignored start done count", 64'(n), 64'd1);
      check("ignored start product", 64'(Product), 64'd63);

      // Reset five cycles into CALC aborts the operation.
      do_start(16'd100, 16'd100);
      repeat (4) @(posedge Clk);
      #1; Rst = 1'b1;
      @(posedge Clk); #1; Rst = 1'b0;
      check("abort busy", 64'(Busy), 64'd0);
      check("abort product", 64'(Product), 64'd0);
      count_done(25, n);
      check("abort no done", 64'(n), 64'd0);
      run_mul("4x4", 16'd4, 16'd4, 32'd16);

      // Rst and Start on the same edge: reset wins.
      @(posedge Clk); #1;
      Rst = 1'b1; Start = 1'b1; A = 16'd9; B = 16'd9;
      @(posedge Clk); #1;
      Rst = 1'b0; Start = 1'b0;
      check("rst+start busy", 64'(Busy), 64'd0);
      count_done(25, n);
      check("rst+start no done", 64'(n), 64'd0);

      // Chained with an accumulator: sums 2, 6, 1030, then 600 after reset.
      @(posedge Clk); #1; Rst = 1'b1;
      @(posedge Clk); #1; Rst = 1'b0;
      do_start(16'd2, 16'd1);
      wait_done("mac 2x1", lat);
      @(posedge Clk); #1;
      check("mac sum 2", 64'(sum), 64'd2);
      do_start(16'd4, 16'd1);
      wait_done("mac 4x1", lat);
      @(posedge Clk); #1;
      check("mac sum 6", 64'(sum), 64'd6);
      do_start(16'd32, 16'd32);
      wait_done("mac 32x32", lat);
      @(posedge Clk); #1;
      check("mac sum 1030", 64'(sum), 64'd1030);
      Rst = 1'b1;
      @(posedge Clk); #1; Rst = 1'b0;
      check("mac reset sum", 64'(sum), 64'd0);
      do_start(16'd600, 16'd1);
      wait_done("mac 600x1", lat);
      @(posedge Clk); #1;
      check("mac sum 600", 64'(sum), 64'd600);

      repeat (3) @(posedge Clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_shift_add_multiplier
